// File: rtl/count_display_driver.sv
// Binary-to-BCD double-dabble converter (one bit per clock) feeding a 3-digit
// time-multiplexed 7-segment display with optional leading-zero blanking.
module count_display_driver #(
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  count,
  output logic [11:0] bcd,
  output logic        valid,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t         state;
  logic [7:0]     last;
  logic [7:0]     shreg;
  logic [11:0]    acc;
  logic [11:0]    adj;
  logic [11:0]    acc_next;
  logic [2:0]     bit_cnt;
  logic           pending;
  logic [PW-1:0]  prescaler;
  logic [1:0]     digit_sel;
  logic [3:0]     digit;
  logic           blank;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    adj = acc;
    for (int i = 0; i < 3; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = {adj[10:0], shreg[7]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bcd     <= 12'h000;
      valid   <= 1'b0;
      busy    <= 1'b0;
      last    <= 8'h00;
      pending <= 1'b1;
      shreg   <= 8'h00;
      acc     <= 12'h000;
      bit_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pending || (count != last)) begin
            shreg   <= count;
            last    <= count;
            acc     <= 12'h000;
            bit_cnt <= 3'd0;
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          acc     <= acc_next;
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            bcd   <= acc_next;
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan timing is free-running from reset release, unrelated to conversions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      digit_sel <= 2'd0;
    end else if (prescaler == PW'(SCAN_DIV - 1)) begin
      prescaler <= '0;
      digit_sel <= (digit_sel == 2'd2) ? 2'd0 : digit_sel + 2'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_comb begin
    digit = bcd[3:0];
    blank = 1'b0;
    an    = 3'b111;
    seg   = 7'h00;
    case (digit_sel)
      2'd1: begin
        digit = bcd[7:4];
        blank = BLANK_LZ && (bcd[11:4] == 8'h00);
      end
      2'd2: begin
        digit = bcd[11:8];
        blank = BLANK_LZ && (bcd[11:8] == 4'h0);
      end
      default: begin
        digit = bcd[3:0];
        blank = 1'b0;
      end
    endcase
    if (valid) begin
      an  = ~(3'b001 << digit_sel);
      seg = blank ? 7'h00 : seg7(digit);
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Directed + randomized bench for count_display_driver; checks against an
// arithmetic decimal/segment model for two parameterisations in parallel.
module tb_count_display_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  count = 8'd0;
  logic [11:0] bcd0, bcd1;
  logic        valid0, valid1, busy0, busy1;
  logic [6:0]  seg0, seg1;
  logic [2:0]  an0, an1;

  count_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u0 (
    .clk(clk), .reset(reset), .count(count), .bcd(bcd0), .valid(valid0),
    .busy(busy0), .seg(seg0), .an(an0)
  );

  count_display_driver #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) u1 (
    .clk(clk), .reset(reset), .count(count), .bcd(bcd1), .valid(valid1),
    .busy(busy1), .seg(seg1), .an(an1)
  );

  always #5 clk = ~clk;

  // Rising edges seen since reset release; drives the expected scan position.
  int edges = 0;
  always @(posedge clk) begin
    if (!reset) edges = 0;
    else edges = edges + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_disp(input int v, input int ncyc);
    int d0, d1, dv0, dv1;
    int digs [3];
    logic [2:0] an_e;
    logic [6:0] seg_e;
    digs[0] = v % 10;
    digs[1] = (v / 10) % 10;
    digs[2] = v / 100;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      d0 = (edges / 4) % 3;
      d1 = edges % 3;
      dv0 = digs[d0];
      dv1 = digs[d1];
      an_e = ~(3'b001 << d0);
      chk("an_div4", an0, an_e);
      if ((d0 == 2 && v < 100) || (d0 == 1 && v < 10)) seg_e = 7'h00;
      else seg_e = seg_tab[dv0];
      chk("seg_blank", seg0, seg_e);
      an_e = ~(3'b001 << d1);
      chk("an_div1", an1, an_e);
      seg_e = seg_tab[dv1];
      chk("seg_noblank", seg1, seg_e);
    end
  endtask

  initial begin
    int v;
    reset = 1'b0;
    count = 8'd0;
    wait_n(5);
    chk("rst_bcd", bcd0, 12'h000);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_an", an0, 3'b111);
    chk("rst_seg", seg0, 7'h00);
    chk("rst_an1", an1, 3'b111);

    // First conversion: busy for exactly 8 cycles after the capture edge.
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("busy_high", busy0, 1'b1);
    end
    @(negedge clk);
    chk("busy_low", busy0, 1'b0);
    chk("first_valid", valid0, 1'b1);
    chk("first_bcd", bcd0, 12'h000);
    check_disp(0, 12);

    count = 8'd255;
    wait_n(17);
    chk("bcd_255", bcd0, 12'h255);
    chk("bcd_255_u1", bcd1, 12'h255);
    check_disp(255, 12);

    // Ramp then hold; final value must land within the 17-cycle bound.
    for (int i = 0; i <= 37; i++) begin
      count = 8'(i);
      wait_n(2);
    end
    wait_n(15);
    chk("bcd_ramp37", bcd0, 12'h037);
    chk("bcd_ramp37_u1", bcd1, 12'h037);
    check_disp(37, 24);

    repeat (6) begin
      v = int'($urandom_range(0, 255));
      count = 8'(v);
      wait_n(17);
      chk("bcd_rand", bcd0, to_bcd(v));
      chk("bcd_rand_u1", bcd1, to_bcd(v));
      check_disp(v, 3);
    end

    // Abort a conversion with an asynchronous reset in its third CONV cycle.
    wait_n(10);
    v = int'($urandom_range(1, 255));
    if (v == int'(count)) v = (v == 255) ? 1 : v + 1;
    count = 8'(v);
    @(negedge clk);
    chk("mid_busy", busy0, 1'b1);
    wait_n(2);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy0, 1'b0);
    chk("arst_valid", valid0, 1'b0);
    chk("arst_an", an0, 3'b111);
    chk("arst_bcd", bcd0, 12'h000);
    chk("arst_seg", seg0, 7'h00);
    wait_n(2);
    reset = 1'b1;
    wait_n(8);
    chk("rerun_not_yet", valid0, 1'b0);
    @(negedge clk);
    chk("rerun_valid", valid0, 1'b1);
    chk("rerun_bcd", bcd0, to_bcd(v));

    // Exhaustive sweep, 10 cycles per value, ending with the 255 -> 0 wrap.
    wait_n(10);
    for (int i = 0; i < 256; i++) begin
      count = 8'(i);
      wait_n(10);
      chk("sweep_bcd", bcd0, to_bcd(i));
    end
    count = 8'd0;
    wait_n(10);
    chk("wrap_bcd", bcd0, 12'h000);
    chk("wrap_bcd_u1", bcd1, 12'h000);
    check_disp(0, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
Downstream consumer of the 8-bit up/down counter's `count` bus. It converts the binary count to three BCD digits with a sequential double-dabble engine (one bit per clock). It then drives a 3-digit, time-multiplexed 7-segment display. The block sits between the counter and the board's display pins, in the same clock domain as the counter.

Parameters:
- SCAN_DIV, 4: clock cycles each digit stays lit; legal range >= 1.
- BLANK_LZ, 1: 1 = blank leading zeros on the hundreds and tens digits; 0 = always show all digits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- count  input  8  binary value from the up/down counter.
- bcd  output  12  {hundreds, tens, ones}, 4 bits each; the last completed conversion.
- valid  output  1  high once at least one conversion has completed since reset.
- busy  output  1  high while the conversion engine is in state CONV.
- seg  output  7  {g,f,e,d,c,b,a}, active-high segments for the currently selected digit.
- an  output  3  active-low digit enables: an[0] = ones, an[1] = tens, an[2] = hundreds.

Behaviour:
- Reset (reset == 0), asynchronous, overrides everything including mid-conversion:
  - state = IDLE, bcd = 12'h000, valid = 0, busy = 0.
  - last = 8'h00, pending = 1, prescaler = 0, digit_sel = 0.
  - an = 3'b111, seg = 7'h00.
  - Any conversion in progress is aborted.
- FSM states: IDLE and CONV.
- IDLE → CONV when pending == 1 or count != last. On that edge:
  - shift register = count, last = count, BCD accumulator = 0, bit_cnt = 0, pending = 0.
  - busy = 1 from this edge.
- CONV, every edge:
  - each accumulator nibble >= 5 gets +3;
  - then {accumulator, shift register} shifts left 1;
  - bit_cnt increments.
- On the 8th CONV edge:
  - bcd is loaded with the final accumulator, valid = 1, busy = 0, state returns to IDLE.
- Latency: capture on edge N, bcd updated on edge N+8. busy is high for exactly 8 cycles.
- count is not sampled during CONV. Changes during CONV are caught on return to IDLE via the `last` compare.
  - Intermediate values may be skipped; the final stable value is always displayed.
  - Worst case from count stable to bcd correct: 17 cycles.
- Hundreds digit is never > 2. Every bcd nibble is always in 0..9.
- Scan prescaler:
  - counts 0..SCAN_DIV-1;
  - at SCAN_DIV-1 it wraps to 0 and digit_sel advances 0 → 1 → 2 → 0;
  - SCAN_DIV == 1 advances every cycle;
  - the prescaler runs from reset release, independent of conversion.
- Display decode (combinational from the registered digit_sel, bcd and valid):
  - valid == 0: an = 3'b111, seg = 7'h00.
  - valid == 1: an = 3'b110 / 3'b101 / 3'b011 for digit_sel = 0 / 1 / 2.
- Segment codes (hex):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F
- Leading-zero blanking (BLANK_LZ = 1):
  - hundreds seg = 7'h00 when hundreds == 0;
  - tens seg = 7'h00 when hundreds == 0 and tens == 0;
  - ones is never blanked;
  - an still asserts for a blanked digit.
- Wrap-around: count 255 → 0 or 0 → 255 needs no special case; it is an ordinary reconvert.

Test Plan:
- Reset low 5 cycles, count = 0, release → busy rises on the first edge after release and falls 8 edges later. Then bcd = 12'h000, valid = 1. Ones shows seg 3F with an = 110; tens and hundreds show seg 00.
- count = 8'd255 held → bcd = 12'h255. Hundreds slot shows an = 011 with seg 5B; tens 6D; ones 6D.
- count ramps up by one every 2 cycles from 0, then holds at 8'd37 → within 17 cycles bcd = 12'h037. Hundreds blank, tens 4F, ones 07. With BLANK_LZ = 0, hundreds shows 3F.
- SCAN_DIV = 4, valid = 1 → an = 110 for 4 cycles, 101 for 4, 011 for 4, then repeats. With SCAN_DIV = 1 the sequence changes every cycle.
- Reset asserted on the 3rd CONV cycle → immediately (asynchronously) busy = 0, valid = 0, an = 111, bcd = 000. After release, a full conversion of the current count completes in 9 edges.
- Exhaustive sweep: count 0..255, each held 10 cycles → bcd equals the decimal value of count every time. Includes the 255 → 0 wrap yielding 12'h000.
